fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle program sequencer for the 9-bit-instruction core.
- Owns the PC, fetches from instruction memory and latches the instruction for the combinational decoder.
- Holds the compare flags and resolves conditional/unconditional jumps.
- Stalls on data-memory ldr/str through a req/ack handshake, and stops on the halt opcode, raising done.

Parameters:
- PC_W, 10, program counter / instruction memory address width.
- INSTR_W, 9, instruction width.
- OFS_W, 8, signed relative jump offset width.
- HALT_OP, 9'h1FF, instruction value that halts the core.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; begins execution from PC 0 when in IDLE.
- imem_addr  out  PC_W  instruction memory address; combinational read, data valid in the same cycle.
- imem_data  in  INSTR_W  instruction word at imem_addr.
- instr  out  INSTR_W  latched instruction, fed to decoder.
- exec_valid  out  1  high for exactly the EXEC cycle; qualifies reg_wr_en and dat_wr_en.
- pc_jmp_en  in  1  decoder: instruction is a jump.
- pc_jmp_abs  in  1  decoder: 1 = absolute target, 0 = PC-relative.
- jmp_cond  in  2  00 never, 01 ge, 10 gt, 11 always.
- jmp_target  in  PC_W  absolute target.
- jmp_ofs  in  OFS_W  signed two's-complement relative offset.
- flag_wr  in  1  decoder: cmp, so latch flags this EXEC.
- alu_ge, alu_gt  in  1 each  ALU compare results.
- mem_op  in  1  decoder: ldr/str needs a data-memory access.
- mem_req  out  1  data-memory request.
- mem_ack  in  1  data-memory completion.
- pc  out  PC_W  current PC.
- done  out  1  core halted.

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, instr=0, flags ge/gt=0, mem_req=0, exec_valid=0, done=0.
- IDLE:
  - start=1 -> FETCH, with pc=0.
  - Otherwise stay.
- FETCH (1 cycle):
  - imem_addr=pc; instr<=imem_data at clock edge.
  - imem_data==HALT_OP -> HALT; otherwise -> EXEC.
- EXEC (1 cycle): exec_valid=1.
  - flag_wr=1: ge<=alu_ge, gt<=alu_gt. New flags are not visible to a jump in the same cycle.
  - mem_op=1 -> MEM_WAIT; mem_req rises at the next edge; pc unchanged.
  - Else if pc_jmp_en and condition true (01: ge, 10: gt, 11: 1, 00: 0):
    - pc <= jmp_target if pc_jmp_abs.
    - Otherwise pc <= pc + sign_extend(jmp_ofs), modulo 2^PC_W.
    - -> FETCH.
  - Else pc <= pc+1 (wraps 2^PC_W-1 -> 0), -> FETCH.
  - mem_op and pc_jmp_en both high: mem_op wins, jump is ignored.
- MEM_WAIT:
  - mem_req=1 (registered).
  - mem_ack sampled only in this state; mem_ack=1 -> mem_req<=0, pc<=pc+1, -> FETCH.
  - No timeout. An ack asserted outside MEM_WAIT is ignored.
- HALT:
  - done=1 (registered); pc holds the halt address; exec_valid=0.
  - start deasserted then reasserted -> pc=0, done=0, FETCH. This is a rising-edge restart, detected with a start_q register.
- start in any state other than IDLE/HALT is ignored.
- Latency:
  - Non-memory instruction: 2 cycles (FETCH + EXEC).
  - Memory instruction: 3 + N cycles, where N is the number of MEM_WAIT cycles before ack.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- When defined:
  - Extra outputs cycle_cnt[31:0] and retired_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle the state is not IDLE/HALT.
  - retired_cnt increments on each EXEC cycle.
  - Both saturate at all-ones and clear on restart from HALT.
- When undefined: the ports and logic are absent.

Decomposition:
- Package fetch_seq_pkg holds:
  - seq_state_e enum {IDLE, FETCH, EXEC, MEM_WAIT, HALT};
  - jmp_cond_e enum {JC_NEVER, JC_GE, JC_GT, JC_ALWAYS};
  - default HALT_OP constant.
- One sub-module, pc_next_calc: combinational next-PC logic (increment, relative add with sign extension, absolute select).

Test Plan:
- Reset hold, then start=1 over imem {0:9'h040, 1:9'h048, 2:9'h1FF} -> pc 0,1,2; exec_valid high on cycles 2 and 4; done=1 at cycle 6; pc stays 2.
- Relative backward jump: pc=5, pc_jmp_en=1, abs=0, jmp_cond=11, jmp_ofs=8'hFE -> next fetch at pc=3.
- Conditional jump:
  - cmp EXEC with alu_ge=1, alu_gt=0, then jge abs target 10'h020 -> pc=0x020.
  - Following jg -> not taken, pc+1.
- Data-memory stall: mem_op=1 at pc=7, mem_ack after 3 MEM_WAIT cycles -> mem_req high exactly 3 cycles, then FETCH at pc=8. An ack pulsed during FETCH has no effect.
- Wrap: pc=10'h3FF non-jump -> pc=0. Relative jump from 10'h3FE with ofs=+4 -> pc=10'h002.
- Async reset asserted mid-MEM_WAIT -> same timestep: mem_req=0, pc=0, state IDLE, flags cleared. A later start runs from pc 0.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, jump
// condition encodings, default halt opcode and the jump-condition evaluator.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM_WAIT,
    HALT
  } seq_state_e;

  typedef enum logic [1:0] {
    JC_NEVER,
    JC_GE,
    JC_GT,
    JC_ALWAYS
  } jmp_cond_e;

  localparam logic [8:0] HALT_OP_DEFAULT = 9'h1FF;

  function automatic logic cond_true(input jmp_cond_e c, input logic ge,
                                     input logic gt);
    logic r;
    case (c)
      JC_GE:     r = ge;
      JC_GT:     r = gt;
      JC_ALWAYS: r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidates: sequential increment and jump target
// (absolute, or PC plus sign-extended offset, both modulo 2^PC_W).
module pc_next_calc #(
  parameter int PC_W  = 10,
  parameter int OFS_W = 8
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             jmp_abs,
  input  logic [PC_W-1:0]  jmp_target,
  input  logic [OFS_W-1:0] jmp_ofs,
  output logic [PC_W-1:0]  pc_inc,
  output logic [PC_W-1:0]  pc_jmp
);

  logic [PC_W-1:0] ofs_ext;

  always_comb begin
    ofs_ext = PC_W'($signed(jmp_ofs));
    pc_inc  = pc + PC_W'(1);
    pc_jmp  = jmp_abs ? jmp_target : pc + ofs_ext;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle program sequencer: PC, fetch/latch, compare flags, jumps,
// data-memory stall handshake and halt. FETCH_SEQ_PERF_EN adds perf counters.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                 PC_W    = 10,
  parameter int                 INSTR_W = 9,
  parameter int                 OFS_W   = 8,
  parameter logic [INSTR_W-1:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               exec_valid,
  input  logic               pc_jmp_en,
  input  logic               pc_jmp_abs,
  input  logic [1:0]         jmp_cond,
  input  logic [PC_W-1:0]    jmp_target,
  input  logic [OFS_W-1:0]   jmp_ofs,
  input  logic               flag_wr,
  input  logic               alu_ge,
  input  logic               alu_gt,
  input  logic               mem_op,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic [PC_W-1:0]    pc,
  output logic               done
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retired_cnt
`endif
);

  seq_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_inc, pc_jmp;
  logic [INSTR_W-1:0]  instr_q;
  logic                ge_q, gt_q, start_q, mem_req_q, done_q;
  logic                jmp_take, restart;

  pc_next_calc #(
    .PC_W (PC_W),
    .OFS_W(OFS_W)
  ) u_pc_next (
    .pc        (pc_q),
    .jmp_abs   (pc_jmp_abs),
    .jmp_target(jmp_target),
    .jmp_ofs   (jmp_ofs),
    .pc_inc    (pc_inc),
    .pc_jmp    (pc_jmp)
  );

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign mem_req    = mem_req_q;
  assign done       = done_q;
  assign exec_valid = (state_q == EXEC);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    restart  = 1'b0;
    // Jumps see the flags registered before this EXEC, never the ones a cmp writes now.
    jmp_take = pc_jmp_en && cond_true(jmp_cond_e'(jmp_cond), ge_q, gt_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH:   state_d = (imem_data == HALT_OP) ? HALT : EXEC;
      EXEC: begin
        if (mem_op) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = FETCH;
          pc_d    = jmp_take ? pc_jmp : pc_inc;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d = FETCH;
          pc_d    = pc_inc;
        end
      end
      HALT: begin
        if (start && !start_q) begin
          state_d = FETCH;
          pc_d    = '0;
          restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      ge_q      <= 1'b0;
      gt_q      <= 1'b0;
      start_q   <= 1'b0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      start_q   <= start;
      mem_req_q <= (state_d == MEM_WAIT);
      done_q    <= (state_d == HALT);
      if (state_q == FETCH) instr_q <= imem_data;
      if (state_q == EXEC && flag_wr) begin
        ge_q <= alu_ge;
        gt_q <= alu_gt;
      end
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else if (restart) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (state_q != IDLE && state_q != HALT && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (state_q == EXEC && retired_cnt != '1)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed programs push expected
// (pc, instr) per EXEC; a negedge monitor pops and compares.
module tb_fetch_sequencer;

  localparam int PC_W = 10;
  localparam int INSTR_W = 9;
  localparam int OFS_W = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               exec_valid;
  logic               pc_jmp_en, pc_jmp_abs, flag_wr, alu_ge, alu_gt, mem_op;
  logic [1:0]         jmp_cond;
  logic [PC_W-1:0]    jmp_target;
  logic [OFS_W-1:0]   jmp_ofs;
  logic               mem_req;
  logic               mem_ack = 1'b0;
  logic [PC_W-1:0]    pc;
  logic               done;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]        cycle_cnt, retired_cnt;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic        jen;
    logic        abs_t;
    logic [1:0]  cond;
    logic [9:0]  target;
    logic [7:0]  ofs;
    logic        fw;
    logic        ge;
    logic        gt;
    logic        mop;
  } ctl_t;

  typedef struct {
    int pc;
    int ins;
  } exp_t;

  ctl_t         ctl [1024];
  logic [8:0]   imem[1024];
  ctl_t         cur;
  exp_t         exp_q[$];
  exp_t         e;
  int           errors = 0;
  int           checks = 0;
  int           ack_after = 0;
  bit           ack_noise = 1'b0;
  int           req_cycles = 0;
  int           wait_n = 0;

  // Instruction memory and a table-driven decoder keyed by the current PC.
  assign imem_data  = imem[imem_addr];
  assign cur        = ctl[pc];
  assign pc_jmp_en  = cur.jen;
  assign pc_jmp_abs = cur.abs_t;
  assign jmp_cond   = cur.cond;
  assign jmp_target = cur.target;
  assign jmp_ofs    = cur.ofs;
  assign flag_wr    = cur.fw;
  assign alu_ge     = cur.ge;
  assign alu_gt     = cur.gt;
  assign mem_op     = cur.mop;

  fetch_sequencer #(
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W),
    .OFS_W  (OFS_W),
    .HALT_OP(9'h1FF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .instr     (instr),
    .exec_valid(exec_valid),
    .pc_jmp_en (pc_jmp_en),
    .pc_jmp_abs(pc_jmp_abs),
    .jmp_cond  (jmp_cond),
    .jmp_target(jmp_target),
    .jmp_ofs   (jmp_ofs),
    .flag_wr   (flag_wr),
    .alu_ge    (alu_ge),
    .alu_gt    (alu_gt),
    .mem_op    (mem_op),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .done      (done)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retired_cnt(retired_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every EXEC cycle must match the next expected instruction.
  always @(negedge clk) begin
    if (exec_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL exec_unexpected: got pc %0h expected no EXEC", pc);
      end else begin
        e = exp_q.pop_front();
        chk("exec_pc", 32'(pc), e.pc);
        chk("exec_instr", 32'(instr), e.ins);
      end
    end
  end

  // Data-memory responder: ack in the Nth MEM_WAIT cycle, optional stray ack otherwise.
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      req_cycles++;
      wait_n++;
      mem_ack = (ack_after != 0 && wait_n == ack_after);
    end else begin
      wait_n  = 0;
      mem_ack = ack_noise;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 9'h000;
      ctl[i]  = '0;
    end
  endtask

  task automatic put_jmp(input int a, input logic ab, input logic [1:0] c,
                         input logic [9:0] t, input logic [7:0] o, input logic [8:0] ins);
    imem[a]       = ins;
    ctl[a].jen    = 1'b1;
    ctl[a].abs_t  = ab;
    ctl[a].cond   = c;
    ctl[a].target = t;
    ctl[a].ofs    = o;
  endtask

  task automatic put_cmp(input int a, input logic ge, input logic gt, input logic [8:0] ins);
    imem[a]   = ins;
    ctl[a].fw = 1'b1;
    ctl[a].ge = ge;
    ctl[a].gt = gt;
  endtask

  task automatic put_mem(input int a, input logic [8:0] ins);
    imem[a]    = ins;
    ctl[a].mop = 1'b1;
  endtask

  task automatic put_halt(input int a);
    imem[a] = 9'h1FF;
  endtask

  task automatic expect_exec(input int a);
    exp_q.push_back('{a, int'(imem[a])});
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_halt(input string name, input int halt_pc, input int max_cyc,
                           output int cyc);
    cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      cyc = i + 1;
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=%b expected 1 within %0d cycles", name, done, max_cyc);
    end
    chk({name, "_halt_pc"}, 32'(pc), halt_pc);
    chk({name, "_halt_instr"}, 32'(instr), 32'h1FF);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    clear_prog();
    do_reset();
    chk("reset_pc", 32'(pc), 0);
    chk("reset_instr", 32'(instr), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_mem_req", 32'(mem_req), 0);
    chk("reset_exec_valid", 32'(exec_valid), 0);

    // Straight-line program ending in halt.
    imem[0] = 9'h040;
    imem[1] = 9'h048;
    put_halt(2);
    expect_exec(0);
    expect_exec(1);
    start = 1'b1;
    wait_halt("basic", 2, 20, cyc);
    chk("basic_halt_latency", cyc, 6);
    repeat (3) @(negedge clk);
    chk("basic_pc_holds", 32'(pc), 2);
    chk("basic_done_holds", 32'(done), 1);

    // Restart from HALT on a start rising edge; relative backward jump 5 -> 3.
    clear_prog();
    put_jmp(0, 1'b1, 2'b11, 10'd5, 8'h00, 9'h011);
    put_jmp(5, 1'b0, 2'b11, 10'd0, 8'hFE, 9'h022);
    put_halt(3);
    expect_exec(0);
    expect_exec(5);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("restart_wait_done", 32'(done), 1);
    start = 1'b1;
    wait_halt("relback", 3, 30, cyc);

    // Conditional jumps: cmp sets ge only; the cmp's own jge must use old flags.
    do_reset();
    clear_prog();
    put_cmp(0, 1'b1, 1'b0, 9'h0C0);
    ctl[0].jen    = 1'b1;
    ctl[0].abs_t  = 1'b1;
    ctl[0].cond   = 2'b01;
    ctl[0].target = 10'h100;
    put_jmp(1, 1'b1, 2'b01, 10'h020, 8'h00, 9'h031);
    put_jmp(10'h020, 1'b1, 2'b10, 10'h100, 8'h00, 9'h032);
    put_halt(10'h021);
    put_halt(10'h100);
    expect_exec(0);
    expect_exec(1);
    expect_exec(10'h020);
    start = 1'b1;
    wait_halt("cond", 10'h021, 30, cyc);

    // Memory stall at pc 7 with a simultaneous jump that must be ignored.
    do_reset();
    clear_prog();
    put_jmp(0, 1'b1, 2'b11, 10'd7, 8'h00, 9'h041);
    put_mem(7, 9'h0A0);
    ctl[7].jen    = 1'b1;
    ctl[7].abs_t  = 1'b1;
    ctl[7].cond   = 2'b11;
    ctl[7].target = 10'h050;
    put_halt(8);
    put_halt(10'h050);
    expect_exec(0);
    expect_exec(7);
    ack_after  = 3;
    ack_noise  = 1'b1;
    req_cycles = 0;
    start = 1'b1;
    wait_halt("mem", 8, 40, cyc);
    chk("mem_req_cycles", req_cycles, 3);
    ack_noise = 1'b0;
    ack_after = 0;

    // Relative jump across the top of the address space: 3FE + 4 -> 002.
    do_reset();
    clear_prog();
    put_jmp(0, 1'b1, 2'b11, 10'h3FE, 8'h00, 9'h051);
    put_jmp(10'h3FE, 1'b0, 2'b11, 10'h000, 8'h04, 9'h052);
    put_halt(2);
    expect_exec(0);
    expect_exec(10'h3FE);
    start = 1'b1;
    wait_halt("relwrap", 2, 30, cyc);

    // Sequential wrap 3FF -> 0; jge at 0 is not taken first, taken second time.
    do_reset();
    clear_prog();
    put_jmp(0, 1'b1, 2'b01, 10'h3FD, 8'h00, 9'h061);
    put_cmp(1, 1'b1, 1'b0, 9'h062);
    put_jmp(2, 1'b1, 2'b11, 10'h3FF, 8'h00, 9'h063);
    imem[10'h3FF] = 9'h064;
    put_halt(10'h3FD);
    expect_exec(0);
    expect_exec(1);
    expect_exec(2);
    expect_exec(10'h3FF);
    expect_exec(0);
    start = 1'b1;
    wait_halt("incwrap", 10'h3FD, 40, cyc);

    // Async reset while stalled in MEM_WAIT, with flags set beforehand.
    do_reset();
    clear_prog();
    put_cmp(0, 1'b1, 1'b1, 9'h071);
    put_mem(1, 9'h072);
    expect_exec(0);
    expect_exec(1);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) break;
    end
    chk("arst_reached_wait", 32'(mem_req), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_pc", 32'(pc), 0);
    chk("arst_exec_valid", 32'(exec_valid), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("arst_queue_empty", exp_q.size(), 0);
    clear_prog();
    put_jmp(0, 1'b1, 2'b01, 10'h010, 8'h00, 9'h081);
    put_halt(1);
    put_halt(10'h010);
    expect_exec(0);
    @(negedge clk);
    start = 1'b1;
    wait_halt("after_arst", 1, 20, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
